// File: rtl/isn_encoder.sv
// Instruction encoder: packs decoded fields into 32-bit words and streams them to imem through a small FIFO.
// Optional build macro ISNENC_RANGECHECK_EN drops out-of-range bundles and pulses err_range.
module isn_encoder #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 12
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        opcode,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        shamt,
   input  logic [4:0]        ALUop,
   input  logic [31:0]       immediate,
   input  logic [31:0]       target,
   input  logic              addr_clr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [31:0]       out_data,
   output logic              wrapped,
   output logic              err_range
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   typedef enum logic [1:0] {
      FMT_R,
      FMT_JI,
      FMT_JII,
      FMT_I
   } fmt_t;

   fmt_t              fmt;
   logic [31:0]       word;
   logic              range_bad;
   logic              accept;
   logic              push;
   logic              pop;
   logic [31:0]       mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;
   logic [31:0]       last_q;
   logic              unused_bits;

   always_comb begin
      fmt = FMT_I;
      case (opcode)
         5'b00000:                            fmt = FMT_R;
         5'b00001, 5'b00011, 5'b10101, 5'b10110: fmt = FMT_JI;
         5'b00100:                            fmt = FMT_JII;
         default:                             fmt = FMT_I;
      endcase
   end

   // Fields not used by the selected format stay zero.
   always_comb begin
      word = '0;
      word[31:27] = opcode;
      case (fmt)
         FMT_R:   word[26:2]  = {rd, rs, rt, shamt, ALUop};
         FMT_JI:  word[26:0]  = target[26:0];
         FMT_JII: word[26:22] = rd;
         default: begin
            word[26:17] = {rd, rs};
            word[16:0]  = immediate[16:0];
         end
      endcase
   end

`ifdef ISNENC_RANGECHECK_EN
   always_comb begin
      range_bad = 1'b0;
      case (fmt)
         FMT_I:   range_bad = ($signed(immediate) < -32'sd65536) ||
                              ($signed(immediate) > 32'sd65535);
         FMT_JI:  range_bad = |target[31:27];
         default: range_bad = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) err_range <= 1'b0;
      else       err_range <= accept && range_bad;
   end
`else
   assign range_bad = 1'b0;
   assign err_range = 1'b0;
`endif

   assign unused_bits = ^{immediate[31:17], target[31:27]};

   assign in_ready  = (count != FULL_CNT);
   // Gated by reset so a queued word is never written during the reset cycle.
   assign out_valid = (count != '0) && !reset;
   assign accept    = in_valid && in_ready;
   assign push      = accept && !range_bad;
   assign pop       = out_valid && out_ready;
   assign out_data  = out_valid ? mem[rd_ptr] : last_q;

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= word;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         last_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            last_q <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_addr <= '0;
         wrapped  <= 1'b0;
      end else begin
         if (addr_clr)  out_addr <= '0;
         else if (pop)  out_addr <= out_addr + 1'b1;
         if (pop && (out_addr == {ADDR_W{1'b1}})) wrapped <= 1'b1;
      end
   end

endmodule

// File: tb/tb_isn_encoder.sv
// Directed bench for isn_encoder: hand-computed encodings, backpressure, address wrap and range handling.
module tb_isn_encoder;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready, in_ready2;
   logic [4:0]  opcode, rd, rs, rt, shamt, ALUop;
   logic [31:0] immediate, target;
   logic        addr_clr;
   logic        out_valid, out_valid2;
   logic        out_ready;
   logic [11:0] out_addr;
   logic [1:0]  out_addr2;
   logic [31:0] out_data, out_data2;
   logic        wrapped, wrapped2;
   logic        err_range, err_range2;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   isn_encoder #(.DEPTH(4), .ADDR_W(12)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .shamt(shamt), .ALUop(ALUop),
      .immediate(immediate), .target(target), .addr_clr(addr_clr),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_data(out_data), .wrapped(wrapped), .err_range(err_range)
   );

   isn_encoder #(.DEPTH(4), .ADDR_W(2)) dut2 (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
      .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .shamt(shamt), .ALUop(ALUop),
      .immediate(immediate), .target(target), .addr_clr(addr_clr),
      .out_valid(out_valid2), .out_ready(out_ready), .out_addr(out_addr2),
      .out_data(out_data2), .wrapped(wrapped2), .err_range(err_range2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic fields(input logic [4:0] op, input logic [4:0] d, input logic [4:0] s,
                         input logic [4:0] t, input logic [4:0] sh, input logic [4:0] alu,
                         input logic [31:0] imm, input logic [31:0] tgt);
      opcode = op; rd = d; rs = s; rt = t; shamt = sh; ALUop = alu;
      immediate = imm; target = tgt;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   logic [31:0] stall_words [5] = '{32'h0040_0000, 32'h0080_0000, 32'h00C0_0000,
                                    32'h0100_0000, 32'h0140_0000};

   initial begin
      #100000;
      $display("FAIL watchdog timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      in_valid = 0; addr_clr = 0; out_ready = 0;
      fields(0, 0, 0, 0, 0, 0, 0, 0);
      do_reset();
      chk("rst_out_valid", {31'd0, out_valid}, 0);
      chk("rst_out_addr", {20'd0, out_addr}, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_wrapped", {31'd0, wrapped}, 0);
      chk("rst_err_range", {31'd0, err_range}, 0);
      chk("rst_in_ready", {31'd0, in_ready}, 1);

      // R-type add
      out_ready = 1;
      fields(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 32'd0, 32'd0);
      in_valid = 1;
      step();
      in_valid = 0;
      chk("add_valid", {31'd0, out_valid}, 1);
      chk("add_data", out_data, 32'h0044_3000);
      chk("add_addr", {20'd0, out_addr}, 0);
      step();
      chk("add_popped", {31'd0, out_valid}, 0);

      // addi then j, back to back
      do_reset();
      fields(5'b00101, 5'd4, 5'd5, 5'd0, 5'd0, 5'd7, 32'hFFFF_FFFF, 32'd0);
      in_valid = 1;
      step();
      fields(5'b00001, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd100);
      chk("addi_data", out_data, 32'h290B_FFFF);
      chk("addi_addr", {20'd0, out_addr}, 0);
      step();
      in_valid = 0;
      chk("j_data", out_data, 32'h0800_0064);
      chk("j_addr", {20'd0, out_addr}, 1);
      step();
      chk("empty_valid", {31'd0, out_valid}, 0);
      chk("empty_hold", out_data, 32'h0800_0064);
      chk("addr_after2", {20'd0, out_addr}, 2);

      // sll and jr
      fields(5'd0, 5'd1, 5'd2, 5'd0, 5'd4, 5'b00100, 32'd0, 32'd0);
      in_valid = 1;
      step();
      fields(5'b00100, 5'd31, 5'd9, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
      chk("sll_data", out_data, 32'h0044_0210);
      chk("sll_addr", {20'd0, out_addr}, 2);
      step();
      in_valid = 0;
      chk("jr_data", out_data, 32'h27C0_0000);
      chk("jr_addr", {20'd0, out_addr}, 3);
      step();

      // backpressure: fill FIFO, 5th bundle waits
      out_ready = 0;
      for (int i = 0; i < 4; i++) begin
         fields(5'd0, 5'(i + 1), 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
         in_valid = 1;
         step();
      end
      chk("full_in_ready", {31'd0, in_ready}, 0);
      fields(5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("stall_ready", {31'd0, in_ready}, 0);
         chk("stall_data", out_data, stall_words[0]);
         chk("stall_addr", {20'd0, out_addr}, 4);
      end
      out_ready = 1;
      step();
      chk("drain_ready", {31'd0, in_ready}, 1);
      for (int i = 1; i < 5; i++) begin
         if (i == 2) in_valid = 0;
         chk("drain_data", out_data, stall_words[i]);
         chk("drain_addr", {20'd0, out_addr}, 32'(4 + i));
         step();
      end
      chk("drain_empty", {31'd0, out_valid}, 0);

      // address wrap on the 2-bit instance, then addr_clr with a pop
      do_reset();
      in_valid = 1;
      for (int k = 0; k < 5; k++) begin
         fields(5'b00001, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'(k));
         step();
         chk("wrap_data", out_data2, 32'h0800_0000 | 32'(k));
         chk("wrap_addr", {30'd0, out_addr2}, 32'(k % 4));
         chk("wrap_flag", {31'd0, wrapped2}, (k == 4) ? 32'd1 : 32'd0);
      end
      in_valid = 0;
      step();
      fields(5'b00001, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd9);
      in_valid = 1;
      step();
      in_valid = 0;
      chk("clr_old_addr", {30'd0, out_addr2}, 1);
      chk("clr_valid", {31'd0, out_valid2}, 1);
      addr_clr = 1;
      step();
      addr_clr = 0;
      chk("clr_new_addr", {30'd0, out_addr2}, 0);
      chk("clr_big_addr", {20'd0, out_addr}, 0);
      chk("clr_wrapped_kept", {31'd0, wrapped2}, 1);
      chk("clr_popped", {31'd0, out_valid2}, 0);

      // reset mid-stream discards queued words
      out_ready = 0;
      fields(5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
      in_valid = 1;
      step();
      step();
      in_valid = 0;
      reset = 1;
      #1;
      chk("rst_cycle_valid", {31'd0, out_valid}, 0);
      step();
      reset = 0;
      step();
      chk("rst_discard", {31'd0, out_valid}, 0);
      chk("rst_discard_rdy", {31'd0, in_ready}, 1);

      // out-of-range immediate
      out_ready = 1;
      fields(5'b00101, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd70000, 32'd0);
      in_valid = 1;
      chk("range_in_ready", {31'd0, in_ready}, 1);
      step();
      in_valid = 0;
`ifdef ISNENC_RANGECHECK_EN
      chk("range_err_pulse", {31'd0, err_range}, 1);
      chk("range_no_write", {31'd0, out_valid}, 0);
      step();
      chk("range_err_drop", {31'd0, err_range}, 0);
      chk("range_still_none", {31'd0, out_valid}, 0);
`else
      chk("trunc_err", {31'd0, err_range}, 0);
      chk("trunc_valid", {31'd0, out_valid}, 1);
      chk("trunc_data", out_data, 32'h2801_1170);
      step();
      chk("trunc_err_after", {31'd0, err_range}, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/isn_encoder.md
# isn_encoder

Packs decoded instruction fields (opcode, registers, shamt, ALUop, immediate, target) back into 32-bit instruction words and streams them, with sequential addresses, into instruction-memory write port. Sits between the test/boot loader and imem. It is the inverse of the instruction decoder and uses the identical field layout. A small FIFO decouples field producers from memory backpressure.

## Interface

- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `ADDR_W`, 12: imem word-address width.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  field bundle present.
- `in_ready`  out  1  encoder can accept bundle.
- `opcode, rd, rs, rt, shamt, ALUop`  in  5 each  instruction fields.
- `immediate`  in  32  signed immediate (I-type).
- `target`  in  32  unsigned jump target (JI-type).
- `addr_clr`  in  1  reset write address to 0.
- `out_valid`  out  1  imem write pending.
- `out_ready`  in  1  imem accepts write.
- `out_addr`  out  ADDR_W  word address of pending write.
- `out_data`  out  32  encoded instruction.
- `wrapped`  out  1  sticky: address counter wrapped.
- `err_range`  out  1  one-cycle pulse: field out of range (macro-dependent).

## Operation

- Field layout: opcode[31:27], rd[26:22], rs[21:17], rt[16:12], shamt[11:7], ALUop[6:2], [1:0]=00; imm[16:0]; target[26:0].
- Format chosen from opcode:
  - R (00000): all register, shamt, and ALUop fields.
  - JI (00001 j, 00011 jal, 10101 setx, 10110 bex): opcode | target[26:0].
  - JII (00100 jr): opcode | rd; other bits 0.
  - I (all others, incl. 00101 addi): opcode | rd | rs | immediate[16:0]. ALUop ignored.
- Unused fields for a format are ignored; their bits are forced to 0.
- Accept when `in_valid && in_ready`. The encoded word is pushed into the FIFO the same edge.
- Pop when `out_valid && out_ready`. `out_addr` then increments, wrapping 2^ADDR_W-1 -> 0. On wrap, `wrapped` sets and stays set until reset.
- `out_data`/`out_addr` are stable while `out_valid && !out_ready`.
- `addr_clr` sets the counter to 0 next edge. It takes priority over a same-cycle pop increment; that pop still writes at the old address. It does not affect FIFO contents or `wrapped`.
- Reset: FIFO empty, `out_valid`=0, `out_addr`=0, `out_data`=0, `wrapped`=0, `err_range`=0, `in_ready`=1.
- Reset mid-stream discards all queued words. No write is issued in the reset cycle.

## Timing

- Latency from accept to `out_valid`: 1 cycle (registered FIFO, no bypass).
- `in_ready` = !full, derived from registered state only. When full, no push occurs even if a pop happens the same cycle.
- Simultaneous push and pop when not full or empty: both occur and the count is unchanged.
- Throughput: 1 word/cycle with `out_ready` held high.
- Empty: `out_valid`=0 and `out_data` holds its last value.

## Configuration

- `ISNENC_RANGECHECK_EN` defined:
  - I-type requires `immediate` in [-65536, 65535]. JI-type requires `target[31:27]`==0.
  - A violating bundle is still accepted (handshake completes) but is not pushed.
  - `err_range` pulses high the cycle after the accept.
- Undefined: values are silently truncated to the field width, every bundle is pushed, and `err_range` is tied 0.

## Test plan

- Reset, then push R-type add (op 0, rd1, rs2, rt3, shamt0, ALUop0) with `out_ready`=1. Expect `out_valid` next cycle, `out_data`=0x00443000, `out_addr`=0.
- Push addi (op 00101, rd4, rs5, imm -1, ALUop 7), then j (op 00001, target 100). Expect 0x290BFFFF at addr 0, then 0x08000064 at addr 1.
- Push sll (rd1, rs2, shamt4, ALUop 00100) and jr $31 (op 00100, rd31, rs 9). Expect 0x00440210 and 0x27C00000.
- Hold `out_ready`=0 and push 5 bundles. Expect `in_ready`=0 after 4, with data/addr stable. Release: 4 writes at consecutive addresses; the 5th is then accepted.
- With ADDR_W=2, write 5 words. Expect addresses 0,1,2,3,0 and `wrapped`=1 from the 5th pop. Assert `addr_clr` with a same-cycle pop: the pop writes at the old address and the next address is 0.
- Macro defined: addi with imm 70000. Expect handshake completes, `err_range` pulses once, no write. Macro undefined: same stimulus writes 0x28000000|0x11170 = 0x28011170.
